// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI controller
// between several one-word transaction requesters.
module spi_txn_arbiter #(
  parameter int NREQ       = 3,
  parameter int DATA_W     = 16,
  parameter int CS_W       = 2,
  parameter int TXN_CYCLES = 46,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*CS_W-1:0]       req_cs,
  input  logic [NREQ*DATA_W-1:0]     req_data,
  input  logic [DATA_W-1:0]          cipo_data,
  output logic                       start_comm,
  output logic [CS_W-1:0]            CS_in,
  output logic [DATA_W-1:0]          data_send_c,
  output logic [NREQ-1:0]            done,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic                       busy
);

  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (TXN_CYCLES > GAP_CYCLES)
                      ? TXN_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] TXN_LAST =
    CW'(TXN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_RST =
    IW'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE,
    GAP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   last;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   win;
  logic            win_ok;

  // Round-robin pick: search from last+1 upward,
  // wrapping at NREQ; the nearest pending one wins.
  always_comb begin
    int idx;
    win    = '0;
    win_ok = 1'b0;
    idx    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        win    = IW'(idx);
        win_ok = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode for the transaction sequence.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (win_ok) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == TXN_LAST) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = GAP;
      end
      GAP: begin
        if (cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Cycle counter shared by WAIT and GAP; cleared
  // on the cycle before each counted phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      unique case (state)
        WAIT,
        GAP:     cnt <= cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // Grant capture: the winner's select and word
  // are frozen here until the next grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last        <= LAST_RST;
      gnt         <= '0;
      CS_in       <= '0;
      data_send_c <= '0;
    end else if (state == IDLE && win_ok) begin
      last        <= win;
      gnt         <= win;
      CS_in       <= req_cs[win*CS_W +: CS_W];
      data_send_c <= req_data[win*DATA_W +: DATA_W];
    end
  end

  // Response capture on the last WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (state == WAIT && cnt == TXN_LAST) begin
      rsp_data <= cipo_data;
      rsp_id   <= gnt;
    end
  end

  // One-hot completion pulse from registered state.
  always_comb begin
    done = '0;
    if (state == DONE) done[gnt] = 1'b1;
  end

  assign start_comm = (state == LAUNCH);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a small
// behavioural SPI peripheral for loopback words.
module tb_spi_txn_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [5:0]  req_cs;
  logic [47:0] req_data;
  logic [15:0] cipo_data;
  logic        start_comm;
  logic [1:0]  CS_in;
  logic [15:0] data_send_c;
  logic [2:0]  done;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int ncmp = 0;
  int nerr = 0;
  int n;

  logic        loop_mode;
  logic [15:0] cipo_dir;
  logic [15:0] model_cipo;
  logic [15:0] psend [4];
  logic [15:0] copi_reg [4];
  logic [5:0]  mcnt;
  logic [1:0]  mcs;
  logic [15:0] mcopi;

  spi_txn_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_cs      (req_cs),
    .req_data    (req_data),
    .cipo_data   (cipo_data),
    .start_comm  (start_comm),
    .CS_in       (CS_in),
    .data_send_c (data_send_c),
    .done        (done),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cipo_data = loop_mode ? model_cipo : cipo_dir;

  // Peripheral: latch COPI word at launch, present
  // its own send word on CIPO well before capture.
  always @(posedge clk) begin
    if (start_comm) begin
      mcnt  <= 6'd30;
      mcs   <= CS_in;
      mcopi <= data_send_c;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1'b1;
      if (mcnt == 6'd1) begin
        model_cipo    <= psend[mcs];
        copi_reg[mcs] <= mcopi;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_done(input int start,
                           input int budget,
                           output int cnt);
    cnt = start;
    do begin
      @(negedge clk);
      cnt++;
    end while (done == 3'b000 && cnt < budget);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_cs    = '0;
    req_data  = '0;
    cipo_dir  = '0;
    loop_mode = 1'b0;
    mcnt      = '0;
    mcs       = '0;
    mcopi     = '0;
    model_cipo = '0;
    for (int j = 0; j < 4; j++) begin
      psend[j]    = '0;
      copi_reg[j] = '0;
    end
    step(1);
    rst = 1'b0;
    step(2);

    chk("rst_busy", busy, 0);
    chk("rst_start", start_comm, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", CS_in, 0);
    chk("rst_dsc", data_send_c, 0);
    chk("rst_rsp", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    rst = 1'b1;

    // single request
    req_cs[1:0]    = 2'd0;
    req_data[15:0] = 16'hA5C3;
    cipo_dir       = 16'h1234;
    req            = 3'b001;
    step(1);
    chk("s_start", start_comm, 1);
    chk("s_cs", CS_in, 0);
    chk("s_dsc", data_send_c, 16'hA5C3);
    chk("s_busy", busy, 1);
    step(1);
    chk("s_start_off", start_comm, 0);
    wait_done(2, 60, n);
    chk("s_lat", n, 48);
    chk("s_done", done, 3'b001);
    chk("s_rsp", rsp_data, 16'h1234);
    chk("s_id", rsp_id, 0);
    chk("s_dsc_hold", data_send_c, 16'hA5C3);
    req = 3'b000;
    step(1);
    chk("s_done_off", done, 0);
    step(2);
    chk("s_idle", busy, 0);

    // simultaneous, from fresh priority
    do_reset();
    req_cs   = {2'd3, 2'd2, 2'd1};
    req_data = {16'h3333, 16'h2222, 16'h1111};
    cipo_dir = 16'hAAAA;
    req      = 3'b111;
    step(1);
    chk("m_cs0", CS_in, 1);
    chk("m_dsc0", data_send_c, 16'h1111);
    wait_done(1, 60, n);
    chk("m_lat0", n, 48);
    chk("m_done0", done, 3'b001);
    chk("m_rsp0", rsp_data, 16'hAAAA);
    req[0]   = 1'b0;
    cipo_dir = 16'hBBBB;
    wait_done(0, 60, n);
    chk("m_per1", n, 51);
    chk("m_done1", done, 3'b010);
    chk("m_id1", rsp_id, 1);
    chk("m_rsp1", rsp_data, 16'hBBBB);
    chk("m_cs1", CS_in, 2);
    req[1] = 1'b0;
    wait_done(0, 60, n);
    chk("m_per2", n, 51);
    chk("m_done2", done, 3'b100);
    chk("m_id2", rsp_id, 2);
    chk("m_dsc2", data_send_c, 16'h3333);
    req[2] = 1'b0;

    // fairness: 1 held, 0 re-requested each time
    req = 3'b011;
    for (int t = 0; t < 4; t++) begin
      wait_done(0, 60, n);
      chk("f_per", n, 51);
      chk("f_id", rsp_id, 32'(t % 2));
      chk("f_done", done, (t % 2) ? 3'b010 : 3'b001);
    end

    // requester 2 drops during WAIT
    req = 3'b100;
    step(10);
    chk("d_busy", busy, 1);
    req = 3'b000;
    wait_done(10, 60, n);
    chk("d_per", n, 51);
    chk("d_done", done, 3'b100);
    step(3);
    step(5);
    chk("d_nogrant", busy, 0);
    chk("d_nostart", start_comm, 0);

    // reset in the middle of WAIT
    req = 3'b010;
    step(20);
    chk("r_busy_pre", busy, 1);
    rst = 1'b0;
    step(1);
    chk("r_busy", busy, 0);
    chk("r_start", start_comm, 0);
    chk("r_done", done, 0);
    chk("r_rsp", rsp_data, 0);
    step(1);
    rst      = 1'b1;
    cipo_dir = 16'hC0DE;
    req      = 3'b110;
    wait_done(0, 60, n);
    chk("r_lat", n, 48);
    chk("r_done1", done, 3'b010);
    chk("r_id", rsp_id, 1);
    chk("r_rsp1", rsp_data, 16'hC0DE);
    req = 3'b000;
    step(3);

    // loopback through the peripheral model
    loop_mode = 1'b1;
    for (int t = 0; t < 20; t++) begin
      int          i;
      logic [1:0]  c;
      logic [15:0] w;
      i = t % 3;
      c = 2'($urandom_range(0, 3));
      w = 16'($urandom);
      psend[c] = 16'($urandom);
      req_cs[i*2 +: 2]    = c;
      req_data[i*16 +: 16] = w;
      req    = 3'b000;
      req[i] = 1'b1;
      wait_done(0, 60, n);
      chk("lb_lat", n, 48);
      chk("lb_rsp", rsp_data, psend[c]);
      chk("lb_copi", copi_reg[c], w);
      chk("lb_id", rsp_id, i);
      req = 3'b000;
      step(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
